// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the riscv_pipeline core.
//   - RV32I opcode / funct3 constants used by the supported subset
//   - ALU operation enum
//   - pipeline register structs (IF/ID, ID/EX, EX/MEM, MEM/WB) and bubbles
//   - immediate extractors and the ID-stage decode helper
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_W    = 3'd2;   // LW / SW

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
    } ifid_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;   // rs fields are 0 when the operand is unused
        logic [31:0] rs1_val, rs2_val, imm;
        alu_op_e     alu_op;
        logic        src_a_pc, src_b_imm, reg_write, mem_read, mem_write;
        logic        branch, jal, jalr;
        logic [2:0]  funct3;
        logic        pred_taken;
    } idex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result, store_data;
        logic [4:0]  rd;
        logic        reg_write, mem_read, mem_write;
    } exmem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] wdata;
    } memwb_t;

    localparam ifid_t  IFID_BUBBLE  = '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR, pred_taken: 1'b0};
    localparam idex_t  IDEX_BUBBLE  = '0;
    localparam exmem_t EXMEM_BUBBLE = '0;
    localparam memwb_t MEMWB_BUBBLE = '0;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction
    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Control decode. Anything unsupported leaves every control bit clear,
    // so it flows down the pipe as a NOP.
    function automatic idex_t decode(input ifid_t f);
        idex_t      d;
        logic [6:0] op;
        logic [2:0] f3;
        logic       alt;
        op  = f.instr[6:0];
        f3  = f.instr[14:12];
        alt = f.instr[30];
        d            = '0;
        d.valid      = f.valid;
        d.pc         = f.pc;
        d.pred_taken = f.pred_taken;
        d.funct3     = f3;
        d.rd         = f.instr[11:7];
        d.alu_op     = ALU_ADD;
        case (op)
            OP_LUI: begin
                d.imm = imm_u(f.instr); d.alu_op = ALU_PASSB;
                d.src_b_imm = 1'b1; d.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                d.imm = imm_u(f.instr); d.src_a_pc = 1'b1;
                d.src_b_imm = 1'b1; d.reg_write = 1'b1;
            end
            OP_JAL: begin
                d.imm = imm_j(f.instr); d.jal = 1'b1; d.reg_write = 1'b1;
            end
            OP_JALR: if (f3 == 3'd0) begin
                d.imm = imm_i(f.instr); d.rs1 = f.instr[19:15]; d.jalr = 1'b1;
                d.src_b_imm = 1'b1; d.reg_write = 1'b1;
            end
            OP_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
                d.imm = imm_b(f.instr); d.branch = 1'b1;
                d.rs1 = f.instr[19:15]; d.rs2 = f.instr[24:20];
            end
            OP_LOAD: if (f3 == F3_W) begin
                d.imm = imm_i(f.instr); d.rs1 = f.instr[19:15];
                d.src_b_imm = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1;
            end
            OP_STORE: if (f3 == F3_W) begin
                d.imm = imm_s(f.instr); d.rs1 = f.instr[19:15]; d.rs2 = f.instr[24:20];
                d.src_b_imm = 1'b1; d.mem_write = 1'b1;
            end
            OP_IMM: begin
                d.imm = imm_i(f.instr);
                case (f3)
                    F3_ADD: d.alu_op = ALU_ADD;
                    F3_SLT: d.alu_op = ALU_SLT;
                    F3_XOR: d.alu_op = ALU_XOR;
                    F3_OR:  d.alu_op = ALU_OR;
                    F3_AND: d.alu_op = ALU_AND;
                    default: d.alu_op = ALU_ADD;
                endcase
                if (f3 == F3_ADD || f3 == F3_SLT || f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND) begin
                    d.rs1 = f.instr[19:15]; d.src_b_imm = 1'b1; d.reg_write = 1'b1;
                end
            end
            OP_REG: begin
                case (f3)
                    F3_ADD: d.alu_op = alt ? ALU_SUB : ALU_ADD;
                    F3_SLL: d.alu_op = ALU_SLL;
                    F3_SLT: d.alu_op = ALU_SLT;
                    F3_XOR: d.alu_op = ALU_XOR;
                    F3_SR:  d.alu_op = alt ? ALU_SRA : ALU_SRL;
                    F3_OR:  d.alu_op = ALU_OR;
                    F3_AND: d.alu_op = ALU_AND;
                    default: d.alu_op = ALU_ADD;
                endcase
                if (f3 != 3'd3) begin
                    d.rs1 = f.instr[19:15]; d.rs2 = f.instr[24:20]; d.reg_write = 1'b1;
                end
            end
            default: ;
        endcase
        // writes to x0 are dropped here so hazard/forward logic never sees them
        if (d.rd == 5'd0) d.reg_write = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational ALU for riscv_pipeline.
//   op      - operation select (alu_op_e)
//   a, b    - operands
//   y       - result
//   eq/lt/ltu - a==b, signed a<b, unsigned a<b (branch conditions)
module riscv_alu
    import riscv_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLT:   y = {31'd0, lt};
            ALU_SLL:   y = a << b[4:0];
            ALU_SRL:   y = a >> b[4:0];
            ALU_SRA:   y = $unsigned($signed(a) >>> b[4:0]);
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/riscv_pipeline.sv
// riscv_pipeline: five-stage in-order RV32I-subset core with private
// instruction memory, data memory and register file.
//   clk, rst_n            - clock; rst_n is an async reset, active HIGH (1 = reset)
//   start                 - 1: load imem[address] <= instruction, core held; 0: run
//   DataOrReg, check_address, value - combinational debug read (dmem or regs)
//   s_data                - external bus read data (combinational response)
//   m_sel, m_rnw, m_addr, m_data    - external bus access from MEM (addr bit 31 set)
// Optional build macro BRANCH_PREDICT_EN adds a 16-entry 2-bit predictor;
// otherwise branches are predicted not taken.
module riscv_pipeline
    import riscv_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [31:0] instruction,
    input  logic        DataOrReg,
    input  logic [31:0] check_address,
    input  logic [31:0] s_data,
    output logic [31:0] value,
    output logic [31:0] m_data,
    output logic [31:0] m_addr,
    output logic        m_sel,
    output logic        m_rnw
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] regs [32];

    logic [31:0] pc;
    ifid_t  ifid;
    idex_t  idex, id_d, id_next;
    exmem_t exmem;
    memwb_t memwb;

    // ---------------- IF ----------------
    logic [31:0] if_instr, if_target;
    logic        if_pred;

    assign if_instr = imem[pc[IW+1:2]];

    always_ff @(posedge clk)
        if (start) imem[address[IW-1:0]] <= instruction;

    // ---------------- ID ----------------
    logic [31:0] id_rs1_val, id_rs2_val;
    logic        stall;

    assign id_d = decode(ifid);

    // write-first register file: a same-cycle WB write bypasses the array
    always_comb begin
        id_rs1_val = regs[id_d.rs1];
        id_rs2_val = regs[id_d.rs2];
        if (memwb.reg_write && memwb.rd == id_d.rs1) id_rs1_val = memwb.wdata;
        if (memwb.reg_write && memwb.rd == id_d.rs2) id_rs2_val = memwb.wdata;
        if (id_d.rs1 == 5'd0) id_rs1_val = '0;
        if (id_d.rs2 == 5'd0) id_rs2_val = '0;
        id_next         = id_d;
        id_next.rs1_val = id_rs1_val;
        id_next.rs2_val = id_rs2_val;
    end

    // load result is not ready until MEM/WB, so a dependent in ID waits one cycle
    assign stall = idex.valid && idex.mem_read && idex.reg_write &&
                   (idex.rd == id_d.rs1 || idex.rd == id_d.rs2);

    // ---------------- EX ----------------
    logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_y;
    logic [31:0] pc_plus4_e, ex_target, ex_result, redirect;
    logic        eq, lt, ltu, cond, branch_e, taken_e, flush;

    // loads never need the EX/MEM path: the load-use stall keeps their consumer out of EX
    always_comb begin
        fwd_a = idex.rs1_val;
        fwd_b = idex.rs2_val;
        if (exmem.reg_write && !exmem.mem_read && exmem.rd == idex.rs1) fwd_a = exmem.result;
        else if (memwb.reg_write && memwb.rd == idex.rs1)                fwd_a = memwb.wdata;
        if (exmem.reg_write && !exmem.mem_read && exmem.rd == idex.rs2) fwd_b = exmem.result;
        else if (memwb.reg_write && memwb.rd == idex.rs2)                fwd_b = memwb.wdata;
    end

    assign alu_a = idex.src_a_pc  ? idex.pc  : fwd_a;
    assign alu_b = idex.src_b_imm ? idex.imm : fwd_b;

    riscv_alu u_alu (
        .op  (idex.alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .y   (alu_y),
        .eq  (eq),
        .lt  (lt),
        .ltu (ltu)
    );

    always_comb begin
        case (idex.funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    assign branch_e   = idex.valid && idex.branch;
    assign taken_e    = (branch_e && cond) || (idex.valid && (idex.jal || idex.jalr));
    assign pc_plus4_e = idex.pc + 32'd4;
    assign ex_target  = idex.jalr ? {alu_y[31:1], 1'b0} : idex.pc + idex.imm;
    assign ex_result  = (idex.jal || idex.jalr) ? pc_plus4_e : alu_y;
    // Covers both builds: without prediction pred_taken is always 0.
    assign flush      = idex.valid && (taken_e != idex.pred_taken);
    assign redirect   = taken_e ? ex_target : pc_plus4_e;

`ifdef BRANCH_PREDICT_EN
    logic [1:0]  bht [16];
    logic [31:0] if_imm;
    logic        if_is_jal, if_is_br;

    assign if_is_jal = (if_instr[6:0] == OP_JAL);
    assign if_is_br  = (if_instr[6:0] == OP_BRANCH);
    assign if_imm    = if_is_jal ? imm_j(if_instr) : imm_b(if_instr);
    assign if_pred   = if_is_jal || (if_is_br && bht[pc[5:2]][1]);
    assign if_target = if_pred ? pc + if_imm : pc + 32'd4;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 16; i++) bht[i] <= 2'b01;
        end else if (branch_e && !start) begin
            if (cond && bht[idex.pc[5:2]] != 2'b11)
                bht[idex.pc[5:2]] <= bht[idex.pc[5:2]] + 2'b01;
            else if (!cond && bht[idex.pc[5:2]] != 2'b00)
                bht[idex.pc[5:2]] <= bht[idex.pc[5:2]] - 2'b01;
        end
    end
`else
    assign if_pred   = 1'b0;
    assign if_target = pc + 32'd4;
`endif

    // ---------------- MEM ----------------
    logic        ext, dmem_we;
    logic [31:0] mem_rdata;

    assign ext       = exmem.result[31];
    assign dmem_we   = exmem.mem_write && !ext;
    assign mem_rdata = ext ? s_data : dmem[exmem.result[DW+1:2]];

    assign m_sel  = exmem.valid && (exmem.mem_read || exmem.mem_write) && ext;
    assign m_rnw  = !(m_sel && exmem.mem_write);
    assign m_addr = m_sel ? exmem.result : '0;
    assign m_data = (m_sel && exmem.mem_write) ? exmem.store_data : '0;

    assign value = DataOrReg ? dmem[check_address[DW-1:0]] : regs[check_address[4:0]];

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc    <= '0;
            ifid  <= IFID_BUBBLE;
            idex  <= IDEX_BUBBLE;
            exmem <= EXMEM_BUBBLE;
            memwb <= MEMWB_BUBBLE;
        end else if (start) begin
            pc    <= '0;
            ifid  <= IFID_BUBBLE;
            idex  <= IDEX_BUBBLE;
            exmem <= EXMEM_BUBBLE;
            memwb <= MEMWB_BUBBLE;
        end else begin
            exmem <= '{valid: idex.valid, result: ex_result, store_data: fwd_b, rd: idex.rd,
                       reg_write: idex.reg_write, mem_read: idex.mem_read,
                       mem_write: idex.mem_write};
            memwb <= '{rd: exmem.rd, reg_write: exmem.reg_write,
                       wdata: exmem.mem_read ? mem_rdata : exmem.result};
            if (flush) begin
                pc   <= redirect & PC_MASK;
                ifid <= IFID_BUBBLE;
                idex <= IDEX_BUBBLE;
            end else if (stall) begin
                idex <= IDEX_BUBBLE;          // pc and ifid hold
            end else begin
                pc   <= if_target & PC_MASK;
                ifid <= '{valid: 1'b1, pc: pc, instr: if_instr, pred_taken: if_pred};
                idex <= id_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (memwb.reg_write) begin
            regs[memwb.rd] <= memwb.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (dmem_we) begin
            dmem[exmem.result[DW+1:2]] <= exmem.store_data;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{address[31:IW], check_address[31:DW]};

endmodule

// File: tb/tb_riscv_pipeline.sv
// Bench for riscv_pipeline: directed programs, expectations queued by the
// stimulus and checked by a monitor when a debug probe or bus access appears.
module tb_riscv_pipeline;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b1;
    logic [31:0] address = '0, instruction = '0, check_address = '0;
    logic        DataOrReg = 1'b0;
    logic [31:0] s_data = 32'h0000_1234;
    logic [31:0] value, m_data, m_addr;
    logic        m_sel, m_rnw;

    riscv_pipeline dut (
        .clk(clk), .rst_n(rst_n), .start(start), .address(address),
        .instruction(instruction), .DataOrReg(DataOrReg), .check_address(check_address),
        .s_data(s_data), .value(value), .m_data(m_data), .m_addr(m_addr),
        .m_sel(m_sel), .m_rnw(m_rnw)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] val;
    } exp_t;

    exp_t        dbg_q[$];
    exp_t        bus_q[$];
    logic [31:0] prog[$];
    logic        probe = 1'b0;
    logic        cnt_en = 1'b0;
    int          total = 0, passed = 0;
    int          br_cnt, fl_cnt, st_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---- instruction encoders ----
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'b0010011);
    endfunction

    // ---- monitor: pops expectations when the DUT presents a probe or bus access ----
    always @(negedge clk) begin
        if (probe) begin
            if (dbg_q.size() == 0) chk("dbg_q_underflow", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = dbg_q.pop_front();
                chk(e.name, value, e.val);
            end
        end
        if (!rst_n && m_sel) begin
            if (bus_q.size() == 0) chk("unexpected_bus", m_addr, 32'd0);
            else begin
                exp_t e;
                e = bus_q.pop_front();
                chk({e.name, "_addr"}, m_addr, e.addr);
                chk({e.name, "_rnw"}, {31'd0, m_rnw}, {31'd0, e.rnw});
                if (!e.rnw) chk({e.name, "_data"}, m_data, e.val);
            end
        end
        if (cnt_en) begin
            if (dut.branch_e) br_cnt++;
            if (dut.flush)    fl_cnt++;
            if (dut.stall)    st_cnt++;
        end
    end

    task automatic probe_chk(input string name, input logic sel, input int idx, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.rnw = 1'b0; e.addr = '0; e.val = exp;
        DataOrReg = sel;
        check_address = 32'(idx);
        dbg_q.push_back(e);
        probe = 1'b1;
        @(negedge clk); #1 probe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_bus(input string name, input logic rnw, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.name = name; e.rnw = rnw; e.addr = a; e.val = d;
        bus_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    // writes prog into imem[0..31], NOP-padded, then releases the core
    task automatic load_run(input int cycles);
        start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            address = i;
            instruction = (i < prog.size()) ? prog[i] : NOP_INSTR;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic loop_prog();
        prog.delete();
        prog.push_back(addi(1, 0, 0));
        prog.push_back(addi(2, 0, 1));
        prog.push_back(addi(3, 0, 11));
        prog.push_back(enc_r(7'd0, 2, 1, 3'd0, 1));   // add x1,x1,x2
        prog.push_back(addi(2, 2, 1));
        prog.push_back(enc_b(-8, 3, 2, 3'd1));         // bne x2,x3,-8
        prog.push_back(enc_s(4, 1, 0));                // sw x1,4(x0)
        prog.push_back(addi(4, 0, 1));
        prog.push_back(enc_s(0, 4, 0));                // sw x4,0(x0)
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(posedge clk); #1;
        chk("rst_m_sel",  {31'd0, m_sel}, 32'd0);
        chk("rst_m_rnw",  {31'd0, m_rnw}, 32'd1);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_pc",     dut.pc, 32'd0);
        probe_chk("rst_x5", 1'b0, 5, 32'd0);
        probe_chk("rst_dmem3", 1'b1, 3, 32'd0);
        rst_n = 1'b0;

        // fill all of imem with NOP so programs run into harmless padding
        for (int i = 0; i < 1024; i++) begin
            address = i; instruction = NOP_INSTR;
            @(posedge clk); #1;
        end

        // EX->EX forwarding
        do_reset();
        prog.delete();
        prog.push_back(addi(1, 0, 5));
        prog.push_back(addi(2, 1, 3));
        load_run(10);
        probe_chk("fwd_x2", 1'b0, 2, 32'd8);
        probe_chk("fwd_x1", 1'b0, 1, 32'd5);

        // store / load / load-use
        do_reset();
        prog.delete();
        prog.push_back(addi(1, 0, 7));
        prog.push_back(enc_s(4, 1, 0));
        prog.push_back(enc_i(4, 0, 3'd2, 2, 7'b0000011)); // lw x2,4(x0)
        prog.push_back(enc_r(7'd0, 2, 2, 3'd0, 3));        // add x3,x2,x2
        br_cnt = 0; fl_cnt = 0; st_cnt = 0; cnt_en = 1'b1;
        load_run(20);
        cnt_en = 1'b0;
        probe_chk("lu_dmem1", 1'b1, 1, 32'd7);
        probe_chk("lu_x3", 1'b0, 3, 32'd14);
        probe_chk("lu_x2", 1'b0, 2, 32'd7);
        chk("lu_stall_cycles", st_cnt, 32'd1);

        // loop summing 1..10
        do_reset();
        loop_prog();
        br_cnt = 0; fl_cnt = 0; st_cnt = 0; cnt_en = 1'b1;
        load_run(150);
        cnt_en = 1'b0;
        probe_chk("loop_dmem0", 1'b1, 0, 32'd1);
        probe_chk("loop_dmem1", 1'b1, 1, 32'd55);
        probe_chk("loop_x2", 1'b0, 2, 32'd11);
        chk("loop_branch_e", br_cnt, 32'd10);
`ifdef BRANCH_PREDICT_EN
        chk("loop_flush", fl_cnt, 32'd2);
`else
        chk("loop_flush", fl_cnt, 32'd9);
`endif

        // external bus
        do_reset();
        prog.delete();
        prog.push_back({20'h80000, 5'd5, 7'b0110111});     // lui x5,0x80000
        prog.push_back(addi(6, 0, 9));
        prog.push_back(enc_s(0, 6, 5));                      // sw x6,0(x5)
        prog.push_back(enc_i(0, 5, 3'd2, 7, 7'b0000011));    // lw x7,0(x5)
        push_bus("bus_sw", 1'b0, 32'h8000_0000, 32'd9);
        push_bus("bus_lw", 1'b1, 32'h8000_0000, 32'd0);
        load_run(12);
        probe_chk("bus_x7", 1'b0, 7, 32'h0000_1234);
        probe_chk("bus_x6", 1'b0, 6, 32'd9);
        chk("bus_q_left", bus_q.size(), 32'd0);

        // async reset mid-loop, then rerun from retained imem
        do_reset();
        loop_prog();
        load_run(20);
        #3 rst_n = 1'b1;
        #1;
        chk("mid_m_sel", {31'd0, m_sel}, 32'd0);
        chk("mid_m_rnw", {31'd0, m_rnw}, 32'd1);
        chk("mid_pc", dut.pc, 32'd0);
        @(posedge clk); #1;
        probe_chk("mid_x1", 1'b0, 1, 32'd0);
        probe_chk("mid_x2", 1'b0, 2, 32'd0);
        rst_n = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        probe_chk("rerun_dmem1", 1'b1, 1, 32'd55);
        probe_chk("rerun_dmem0", 1'b1, 0, 32'd1);

        // wrong-path squash
        do_reset();
        prog.delete();
        prog.push_back(enc_b(8, 0, 0, 3'd0));   // beq x0,x0,+8
        prog.push_back(addi(1, 0, 1));
        prog.push_back(addi(2, 0, 2));
        load_run(12);
        probe_chk("squash_x1", 1'b0, 1, 32'd0);
        probe_chk("squash_x2", 1'b0, 2, 32'd2);

        repeat (3) @(posedge clk);
        chk("dbg_q_left", dbg_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
